// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: counter widths,
// the standard (768) and wide (1024) timing presets, and the raw sync bundle.
package video_timing_pkg;

    localparam int XBITS = 11;
    localparam int YBITS = 10;

    // Standard preset
    localparam int STD_H_ACTIVE = 768;
    localparam int STD_H_FP     = 24;
    localparam int STD_H_SYNC   = 72;
    localparam int STD_H_BP     = 80;
    localparam int STD_V_ACTIVE = 576;
    localparam int STD_V_FP     = 3;
    localparam int STD_V_SYNC   = 4;
    localparam int STD_V_BP     = 17;

    // Wide preset: only the visible width differs
    localparam int WIDE_H_ACTIVE = 1024;
    localparam int WIDE_H_FP     = STD_H_FP;
    localparam int WIDE_H_SYNC   = STD_H_SYNC;
    localparam int WIDE_H_BP     = STD_H_BP;
    localparam int WIDE_V_ACTIVE = STD_V_ACTIVE;
    localparam int WIDE_V_FP     = STD_V_FP;
    localparam int WIDE_V_SYNC   = STD_V_SYNC;
    localparam int WIDE_V_BP     = STD_V_BP;

    // Undelayed timing terms, all active-high; zero is the idle value.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } raw_t;

endpackage

// File: rtl/video_timing_sync_delay.sv
// sync_delay: DEPTH-stage enabled shift register with synchronous reset value.
// Ports: clk, reset, en_i (advance), d_i (stage-0 input), q_o (last stage).
module sync_delay
    import video_timing_pkg::*;
#(
    parameter int               DEPTH   = 3,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= RST_VAL;
            end
        end else if (en_i) begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// video_timing: raster x/y counters plus de/hsync/vsync delayed to match
// the renderer's registered pixel. Ports: clk, reset, pix_ce in; x, y,
// frame_start, de, hsync, vsync out. Everything holds while pix_ce is low.
module video_timing
    import video_timing_pkg::*;
#(
    parameter bit VIDEO_WIDE = 1'b0,
    parameter int H_ACTIVE   = VIDEO_WIDE ? WIDE_H_ACTIVE : STD_H_ACTIVE,
    parameter int H_FP       = VIDEO_WIDE ? WIDE_H_FP     : STD_H_FP,
    parameter int H_SYNC     = VIDEO_WIDE ? WIDE_H_SYNC   : STD_H_SYNC,
    parameter int H_BP       = VIDEO_WIDE ? WIDE_H_BP     : STD_H_BP,
    parameter int V_ACTIVE   = VIDEO_WIDE ? WIDE_V_ACTIVE : STD_V_ACTIVE,
    parameter int V_FP       = VIDEO_WIDE ? WIDE_V_FP     : STD_V_FP,
    parameter int V_SYNC     = VIDEO_WIDE ? WIDE_V_SYNC   : STD_V_SYNC,
    parameter int V_BP       = VIDEO_WIDE ? WIDE_V_BP     : STD_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SYNC_DELAY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_ce,
    output logic [XBITS-1:0] x,
    output logic [YBITS-1:0] y,
    output logic             frame_start,
    output logic             de,
    output logic             hsync,
    output logic             vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = XBITS + 1;
    localparam int YW      = YBITS + 1;

    if (H_TOTAL > 2048 || V_TOTAL > 1024 || SYNC_DELAY < 1) begin : g_bad_cfg
        $error("video_timing: illegal timing parameters");
    end

    // Compare with one spare bit so a sync ending exactly at 2048/1024
    // does not wrap to zero.
    localparam logic [XW-1:0] HA_C  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS0_C = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS1_C = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VA_C  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS0_C = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS1_C = YW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [XBITS-1:0] X_LAST = XBITS'(H_TOTAL - 1);
    localparam logic [YBITS-1:0] Y_LAST = YBITS'(V_TOTAL - 1);

    logic [XBITS-1:0] x_q, x_d;
    logic [YBITS-1:0] y_q, y_d;
    logic [XW-1:0]    xe;
    logic [YW-1:0]    ye;
    raw_t             raw, dly;

    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pix_ce) begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign xe = {1'b0, x_q};
    assign ye = {1'b0, y_q};

    // vs depends on y only, so it can change only where x wraps to 0.
    assign raw.de = (xe < HA_C) && (ye < VA_C);
    assign raw.hs = (xe >= HS0_C) && (xe < HS1_C);
    assign raw.vs = (ye >= VS0_C) && (ye < VS1_C);

    sync_delay #(
        .DEPTH   (SYNC_DELAY),
        .WIDTH   (3),
        .RST_VAL (3'b000)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en_i  (pix_ce),
        .d_i   (raw),
        .q_o   (dly)
    );

    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = pix_ce && !reset && (x_q == '0) && (y_q == '0);
    assign de          = dly.de;
    assign hsync       = dly.hs ^ ~HS_POL;
    assign vsync       = dly.vs ^ ~VS_POL;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a standard and a wide instance (short frames)
// driven together, checked per cycle against a scoreboard plus monitors.
module tb_video_timing;
    import video_timing_pkg::*;

    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VA + VF + VS + VB;

    function automatic int ha(int i);  return i ? 1024 : 768;  endfunction
    function automatic int ht(int i);  return i ? 1200 : 944;  endfunction
    function automatic int hss(int i); return i ? 1048 : 792;  endfunction
    function automatic int dl(int i);  return i ? 2 : 3;       endfunction
    function automatic bit pol(int i); return i ? 1'b1 : 1'b0; endfunction

    typedef struct {
        int inst;
        int x;
        int y;
        bit fs;
        bit de;
        bit hs;
        bit vs;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             pix_ce;
    logic [XBITS-1:0] xo [2];
    logic [YBITS-1:0] yo [2];
    logic             fs [2];
    logic             de [2];
    logic             hs [2];
    logic             vs [2];

    int n_chk  = 0;
    int n_pass = 0;

    exp_t     sb [$];
    int       mx [2];
    int       my [2];
    bit [2:0] pl [2][3];
    bit       pr;
    bit       pce;
    bit       mon_en = 1'b0;

    always #5 clk = ~clk;

    video_timing #(
        .VIDEO_WIDE (1'b0),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VS),
        .V_BP       (VB)
    ) u_std (
        .clk         (clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .x           (xo[0]),
        .y           (yo[0]),
        .frame_start (fs[0]),
        .de          (de[0]),
        .hsync       (hs[0]),
        .vsync       (vs[0])
    );

    video_timing #(
        .VIDEO_WIDE (1'b1),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VS),
        .V_BP       (VB),
        .HS_POL     (1'b1),
        .VS_POL     (1'b1),
        .SYNC_DELAY (2)
    ) u_wide (
        .clk         (clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .x           (xo[1]),
        .y           (yo[1]),
        .frame_start (fs[1]),
        .de          (de[1]),
        .hsync       (hs[1]),
        .vsync       (vs[1])
    );

    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_chk);
    endtask

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
            if (n_chk - n_pass >= 100) begin
                summary();
                $finish;
            end
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit [2:0] raw(int i);
        bit d, h, v;
        d = mx[i] < ha(i) && my[i] < VA;
        h = mx[i] >= hss(i) && mx[i] < hss(i) + 72;
        v = my[i] >= VA + VF && my[i] < VA + VF + VS;
        return {d, h, v};
    endfunction

    // Reference model: one clock edge with the inputs the DUT sampled.
    task automatic mdl_edge(input bit r, input bit ce);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                mx[i] = 0;
                my[i] = 0;
                for (int k = 0; k < 3; k++) pl[i][k] = 3'b000;
            end else if (ce) begin
                for (int k = 2; k > 0; k--) pl[i][k] = pl[i][k-1];
                pl[i][0] = raw(i);
                if (mx[i] == ht(i) - 1) begin
                    mx[i] = 0;
                    my[i] = (my[i] == VT - 1) ? 0 : my[i] + 1;
                end else begin
                    mx[i] = mx[i] + 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit ce);
        exp_t e;
        bit [2:0] o;
        @(posedge clk);
        mdl_edge(pr, pce);
        #1;
        reset  = r;
        pix_ce = ce;
        pr     = r;
        pce    = ce;
        for (int i = 0; i < 2; i++) begin
            o      = pl[i][dl(i)-1];
            e.inst = i;
            e.x    = mx[i];
            e.y    = my[i];
            e.fs   = ce && !r && mx[i] == 0 && my[i] == 0;
            e.de   = o[2];
            e.hs   = o[1] ? pol(i) : !pol(i);
            e.vs   = o[0] ? pol(i) : !pol(i);
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("x%0d", e.inst), 32'(xo[e.inst]), e.x);
            chk($sformatf("y%0d", e.inst), 32'(yo[e.inst]), e.y);
            chk($sformatf("fs%0d", e.inst), 32'(fs[e.inst]), 32'(e.fs));
            chk($sformatf("de%0d", e.inst), 32'(de[e.inst]), 32'(e.de));
            chk($sformatf("hs%0d", e.inst), 32'(hs[e.inst]), 32'(e.hs));
            chk($sformatf("vs%0d", e.inst), 32'(vs[e.inst]), 32'(e.vs));
        end
    end

    // Independent monitors: pulse widths, edge positions, frame period.
    int hlow, dwide, prev_hs, prev_vs;
    int fcnt [2];
    bit fseen [2];

    always @(negedge clk) begin
        if (!mon_en) begin
            hlow    = 0;
            dwide   = 0;
            prev_hs = 1;
            prev_vs = 1;
            for (int i = 0; i < 2; i++) begin
                fcnt[i]  = 0;
                fseen[i] = 1'b0;
            end
        end else begin
            if (hs[0] === 1'b0 && prev_hs == 1) chk("hs_fall_x", 32'(xo[0]), 795);
            if (vs[0] === 1'b0 && prev_vs == 1) begin
                chk("vs_fall_x", 32'(xo[0]), 3);
                chk("vs_fall_y", 32'(yo[0]), VA + VF);
            end
            prev_hs = int'(hs[0]);
            prev_vs = int'(vs[0]);
            if (hs[0] === 1'b0) begin
                if (pix_ce) hlow++;
            end else if (hlow > 0) begin
                chk("hs_len", hlow, 72);
                hlow = 0;
            end
            if (de[1] === 1'b1) begin
                if (pix_ce) dwide++;
            end else if (dwide > 0) begin
                chk("de_wide_len", dwide, 1024);
                dwide = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (fs[i] === 1'b1) begin
                    if (fseen[i]) chk($sformatf("fs_period%0d", i), fcnt[i], ht(i) * VT);
                    fcnt[i]  = 0;
                    fseen[i] = 1'b1;
                end
                if (pix_ce) fcnt[i]++;
            end
        end
    end

    initial begin
        int k;
        reset  = 1'b1;
        pix_ce = 1'b1;
        pr     = 1'b1;
        pce    = 1'b1;
        repeat (5) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        @(negedge clk);
        chk("rel_x", 32'(xo[0]), 0);
        chk("rel_y", 32'(yo[0]), 0);
        chk("rel_fs", 32'(fs[0]), 1);
        chk("rel_hs", 32'(hs[0]), 1);
        chk("rel_vs", 32'(vs[0]), 1);
        mon_en = 1'b1;

        k = 0;
        while (de[0] !== 1'b1 && k < 10) begin
            cyc(1'b0, 1'b1);
            k++;
        end
        chk("de_latency", k, 3);

        repeat (10000) cyc(1'b0, 1'b1);
        repeat (10000) begin
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b0);
        end

        mon_en = 1'b0;
        k = 0;
        while (!(xo[0] == 11'd799 && yo[0] == 10'd3) && k < 20000) begin
            cyc(1'b0, 1'b1);
            k++;
        end
        chk("reach_799_3", 32'(k < 20000), 1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        @(negedge clk);
        chk("mid_rst_x", 32'(xo[0]), 0);
        chk("mid_rst_y", 32'(yo[0]), 0);
        chk("mid_rst_hs", 32'(hs[0]), 1);
        chk("mid_rst_de", 32'(de[0]), 0);
        mon_en = 1'b1;
        repeat (2000) cyc(1'b0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        summary();
        $finish;
    end

endmodule
